// File: rtl/gpio_in_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gpio_in_ctrl_pkg
//
// Shared definitions for the GPIO input-side controller: register byte
// offsets, the register-select enum and the address decoder. Software headers
// and the testbench pull the offsets from here so that everybody agrees on
// the register map.
//
// Contents:
//   GPIO_IN_LEVEL / _RISE_EN / _FALL_EN / _PENDING : byte offsets
//   regSel_e                                       : decoded register
//   decodeReg()                                    : byte address -> regSel_e
// ---------------------------------------------------------------------------
package gpio_in_ctrl_pkg;

    // Register byte offsets
    localparam logic [3:0] GPIO_IN_LEVEL   = 4'h0;
    localparam logic [3:0] GPIO_IN_RISE_EN = 4'h4;
    localparam logic [3:0] GPIO_IN_FALL_EN = 4'h8;
    localparam logic [3:0] GPIO_IN_PENDING = 4'hC;

    // Width of the debounce counter inside each bit slice
    localparam int unsigned DEBOUNCE_CNT_W = 8;

    typedef enum logic [1:0] {
        REG_LEVEL   = 2'd0,
        REG_RISE_EN = 2'd1,
        REG_FALL_EN = 2'd2,
        REG_PENDING = 2'd3
    } regSel_e;

    // Accesses are word aligned, so the two byte-lane bits are don't-care and
    // each word decodes from four byte addresses.
    function automatic regSel_e decodeReg(input logic [3:0] addr);
        regSel_e sel;
        sel = REG_LEVEL;
        case (addr)
            4'h0, 4'h1, 4'h2, 4'h3: sel = REG_LEVEL;
            4'h4, 4'h5, 4'h6, 4'h7: sel = REG_RISE_EN;
            4'h8, 4'h9, 4'hA, 4'hB: sel = REG_FALL_EN;
            default:                sel = REG_PENDING;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_in_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
//
// One-bit input conditioner: a two-flop synchronizer followed by a debounce
// counter and the debounced level flop. The level only follows the
// synchronized input after it has differed from the current level for
// DEBOUNCE_LEN consecutive cycles; shorter glitches are dropped.
//
// Ports:
//   clk          in  : clock, all state on the rising edge
//   reset_       in  : synchronous active-low reset
//   din_i        in  : raw pad input, asynchronous to clk
//   level_o      out : current debounced level
//   level_next_o out : level that will be loaded on the next edge, used by
//                      the parent for edge detection
// ---------------------------------------------------------------------------
module gpio_debounce
    import gpio_in_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LEN = 4
) (
    input  logic clk,
    input  logic reset_,
    input  logic din_i,
    output logic level_o,
    output logic level_next_o
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_LEN - 1);

    logic                      syncMeta_q;
    logic                      sync_q;
    logic [DEBOUNCE_CNT_W-1:0] cnt_q;
    logic [DEBOUNCE_CNT_W-1:0] cnt_d;
    logic                      level_q;
    logic                      level_d;

    // Synchronizer chain, counter and level flop. Reset discards any partial
    // debounce count along with the synchronizer contents.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            syncMeta_q <= 1'b0;
            sync_q     <= 1'b0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
        end else begin
            syncMeta_q <= din_i;
            sync_q     <= syncMeta_q;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
        end
    end

    // The counter measures how long the synchronized input has disagreed
    // with the level. Any agreement restarts it; reaching DEBOUNCE_LEN-1
    // while still disagreeing means this is the DEBOUNCE_LEN-th cycle, so
    // the level takes the new value and the counter restarts.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/gpio_in_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_in_ctrl
//
// GPIO input-side controller. Every gpio_di bit is synchronized and debounced
// by its own gpio_debounce slice. Edges of the debounced level set sticky
// pending flags (filtered by per-bit rise/fall enables), which are ORed into
// a single level interrupt. The CPU sees four word registers:
//   0x0 LEVEL (RO), 0x4 RISE_EN (RW), 0x8 FALL_EN (RW), 0xC PENDING (R/W1C)
//
// Ports:
//   clk        in  : clock
//   reset_     in  : synchronous active-low reset
//   gpio_di    in  : raw pad inputs, NR_GPIOS wide
//   req_valid  in  : register access request
//   req_ready  out : always 1, requests accepted when valid
//   req_wr     in  : 1 = write, 0 = read
//   req_addr   in  : byte address (bits [1:0] ignored)
//   req_wdata  in  : write data
//   rsp_valid  out : one-cycle pulse, one cycle after each accepted request
//   rsp_rdata  out : read data, valid with rsp_valid, 0 for writes
//   irq        out : OR of pending & (rise_en | fall_en)
// ---------------------------------------------------------------------------
module gpio_in_ctrl
    import gpio_in_ctrl_pkg::*;
#(
    parameter int unsigned NR_GPIOS     = 8,
    parameter int unsigned DEBOUNCE_LEN = 4
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [NR_GPIOS-1:0] gpio_di,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [3:0]          req_addr,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                irq
);

    // Write data is 32 bits but the registers only hold NR_GPIOS bits; the
    // upper bits are simply dropped.
    function automatic logic [NR_GPIOS-1:0] fitWidth(input logic [31:0] word);
        return word[NR_GPIOS-1:0];
    endfunction

    logic [NR_GPIOS-1:0] level;
    logic [NR_GPIOS-1:0] levelNext;
    logic [NR_GPIOS-1:0] riseEv;
    logic [NR_GPIOS-1:0] fallEv;
    logic [NR_GPIOS-1:0] setEv;

    logic [NR_GPIOS-1:0] riseEn_q;
    logic [NR_GPIOS-1:0] riseEn_d;
    logic [NR_GPIOS-1:0] fallEn_q;
    logic [NR_GPIOS-1:0] fallEn_d;
    logic [NR_GPIOS-1:0] pending_q;
    logic [NR_GPIOS-1:0] pending_d;
    logic                rspValid_q;
    logic                rspValid_d;
    logic [31:0]         rspRdata_q;
    logic [31:0]         rspRdata_d;

    regSel_e             regSel;
    logic                wrEn;
    logic                rdEn;
    logic [NR_GPIOS-1:0] wrBits;
    logic [NR_GPIOS-1:0] w1cMask;
    logic [31:0]         readMux;

    // One conditioner per input bit
    for (genvar g = 0; g < NR_GPIOS; g++) begin : gen_debounce
        gpio_debounce #(
            .DEBOUNCE_LEN (DEBOUNCE_LEN)
        ) u_debounce (
            .clk          (clk),
            .reset_       (reset_),
            .din_i        (gpio_di[g]),
            .level_o      (level[g]),
            .level_next_o (levelNext[g])
        );
    end

    // Edges are taken from the level update itself so that pending and irq
    // change on the very edge that LEVEL changes, with no extra pipeline.
    assign riseEv = ~level & levelNext;
    assign fallEv = level & ~levelNext;
    assign setEv  = (riseEv & riseEn_q) | (fallEv & fallEn_q);

    assign req_ready = 1'b1;
    assign regSel    = decodeReg(req_addr);
    assign wrEn      = req_valid & req_wr;
    assign rdEn      = req_valid & ~req_wr;
    assign wrBits    = fitWidth(req_wdata);

    // Read data is taken from the current register values, so a read sees
    // the state before any update happening on the same edge.
    always_comb begin
        readMux = '0;
        case (regSel)
            REG_LEVEL:   readMux = 32'(level);
            REG_RISE_EN: readMux = 32'(riseEn_q);
            REG_FALL_EN: readMux = 32'(fallEn_q);
            REG_PENDING: readMux = 32'(pending_q);
            default:     readMux = '0;
        endcase
    end

    // Register writes and the pending update. The set term is ORed in after
    // the W1C clear so a new event beats a simultaneous clear of that bit.
    // Enable writes only affect events from the following edge onward.
    always_comb begin
        riseEn_d = riseEn_q;
        fallEn_d = fallEn_q;
        w1cMask  = '0;
        if (wrEn) begin
            case (regSel)
                REG_RISE_EN: riseEn_d = wrBits;
                REG_FALL_EN: fallEn_d = wrBits;
                REG_PENDING: w1cMask  = wrBits;
                default:     ;
            endcase
        end
        pending_d = (pending_q & ~w1cMask) | setEv;
    end

    // Response pipe: one registered response for every accepted request.
    always_comb begin
        rspValid_d = req_valid;
        rspRdata_d = rdEn ? readMux : 32'h0;
    end

    // Register state. Reset also squashes a response for a request that was
    // presented while reset was asserted.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            riseEn_q   <= '0;
            fallEn_q   <= '0;
            pending_q  <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            riseEn_q   <= riseEn_d;
            fallEn_q   <= fallEn_d;
            pending_q  <= pending_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign irq       = |(pending_q & (riseEn_q | fallEn_q));

endmodule

// File: tb/tb_gpio_in_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_in_ctrl
//
// Self-checking bench for gpio_in_ctrl (NR_GPIOS=8, DEBOUNCE_LEN=4). A
// reference model records the pad input and reset history edge by edge and
// decides level changes by looking back over the last DEBOUNCE_LEN
// synchronized samples. Directed scenarios are followed by a random phase.
// ---------------------------------------------------------------------------
module tb_gpio_in_ctrl;
    import gpio_in_ctrl_pkg::*;

    localparam int NR = 8;
    localparam int DL = 4;
    localparam int HIST = 8192;

    logic          clk = 1'b0;
    logic          reset_;
    logic [NR-1:0] gpio_di;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [3:0]    req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          irq;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [NR-1:0] rawH [HIST];
    bit            rstH [HIST];
    int            edgeN = 0;
    int            mLast [NR];
    logic [NR-1:0] mLevel = '0;
    logic [NR-1:0] mRise  = '0;
    logic [NR-1:0] mFall  = '0;
    logic [NR-1:0] mPend  = '0;
    logic          mRspValid = 1'b0;
    logic [31:0]   mRspData  = '0;

    always #5 clk = ~clk;

    gpio_in_ctrl #(
        .NR_GPIOS     (NR),
        .DEBOUNCE_LEN (DL)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .gpio_di   (gpio_di),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .irq       (irq)
    );

    // Value the synchronizer presents just before edge j: the pad value seen
    // two edges earlier, or 0 if either of the last two edges was in reset.
    function automatic logic [NR-1:0] syncAt(input int j);
        if (j < 2) return '0;
        if (rstH[j-1] || rstH[j-2]) return '0;
        return rawH[j-2];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across the coming edge using the inputs as driven now.
    task automatic modelStep();
        int            k;
        logic [NR-1:0] newLevel;
        logic [NR-1:0] flips;
        logic [NR-1:0] setBits;
        logic [NR-1:0] clrBits;
        logic [NR-1:0] s;
        logic [3:0]    wordAddr;
        bit            allDiff;
        k = edgeN;
        rawH[k] = gpio_di;
        rstH[k] = !reset_;
        if (!reset_) begin
            mLevel    = '0;
            mRise     = '0;
            mFall     = '0;
            mPend     = '0;
            mRspValid = 1'b0;
            mRspData  = '0;
            for (int i = 0; i < NR; i++) mLast[i] = k;
        end else begin
            wordAddr  = {req_addr[3:2], 2'b00};
            mRspValid = req_valid;
            mRspData  = '0;
            if (req_valid && !req_wr) begin
                if (wordAddr == GPIO_IN_LEVEL)   mRspData = 32'(mLevel);
                if (wordAddr == GPIO_IN_RISE_EN) mRspData = 32'(mRise);
                if (wordAddr == GPIO_IN_FALL_EN) mRspData = 32'(mFall);
                if (wordAddr == GPIO_IN_PENDING) mRspData = 32'(mPend);
            end
            // A bit flips once the last DL synchronized samples since its
            // previous flip (or reset) all disagree with its level.
            flips = '0;
            for (int i = 0; i < NR; i++) begin
                if (k - mLast[i] >= DL) begin
                    allDiff = 1'b1;
                    for (int j = k - DL + 1; j <= k; j++) begin
                        s = syncAt(j);
                        if (s[i] == mLevel[i]) allDiff = 1'b0;
                    end
                    if (allDiff) begin
                        flips[i] = 1'b1;
                        mLast[i] = k;
                    end
                end
            end
            newLevel = mLevel ^ flips;
            setBits  = (flips & newLevel & mRise) | (flips & ~newLevel & mFall);
            clrBits  = '0;
            if (req_valid && req_wr) begin
                if (wordAddr == GPIO_IN_RISE_EN) mRise   = req_wdata[NR-1:0];
                if (wordAddr == GPIO_IN_FALL_EN) mFall   = req_wdata[NR-1:0];
                if (wordAddr == GPIO_IN_PENDING) clrBits = req_wdata[NR-1:0];
            end
            mPend  = (mPend & ~clrBits) | setBits;
            mLevel = newLevel;
        end
        edgeN++;
    endtask

    // One clock: update the model, take the edge, then compare every output.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'h1);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(mRspValid));
        if (mRspValid) checkOutput("rsp_rdata", rsp_rdata, mRspData);
        checkOutput("irq", 32'(irq), 32'(|(mPend & (mRise | mFall))));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic wrReg(input logic [3:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data;
        applyStimulus();
        req_valid = 1'b0; req_wr = 1'b0;
    endtask

    task automatic rdExpect(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = addr;
        applyStimulus();
        req_valid = 1'b0;
        checkOutput(tag, rsp_rdata, exp);
    endtask

    initial begin
        int holdLeft;
        reset_ = 1'b0; gpio_di = 8'h01;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;

        // 1: pin 0 high through reset, debounces to 1 on the 6th edge after release
        idle(3);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);
        reset_ = 1'b1;
        rdExpect("level after reset", GPIO_IN_LEVEL, 32'h00);
        idle(4);
        rdExpect("level before 6th edge", GPIO_IN_LEVEL, 32'h00);
        rdExpect("level after 6th edge", GPIO_IN_LEVEL, 32'h01);
        rdExpect("pending after reset", GPIO_IN_PENDING, 32'h00);
        checkOutput("irq after reset", 32'(irq), 32'h0);

        // 2: rising edge on bit 2 with RISE_EN[2]
        wrReg(GPIO_IN_RISE_EN, 32'h04);
        gpio_di = 8'h05;
        idle(5);
        checkOutput("irq at 5th edge", 32'(irq), 32'h0);
        idle(1);
        checkOutput("irq at 6th edge", 32'(irq), 32'h1);
        rdExpect("pending rise bit2", GPIO_IN_PENDING, 32'h04);
        rdExpect("level bit2", GPIO_IN_LEVEL, 32'h05);
        wrReg(GPIO_IN_PENDING, 32'h04);
        checkOutput("irq after w1c", 32'(irq), 32'h0);
        rdExpect("pending after w1c", GPIO_IN_PENDING, 32'h00);

        // 3: short glitch filtered, long pulse gives rise and fall on bit 3
        wrReg(GPIO_IN_RISE_EN, 32'hFF);
        wrReg(GPIO_IN_FALL_EN, 32'hFF);
        gpio_di = 8'h0D; idle(3);
        gpio_di = 8'h05; idle(8);
        rdExpect("level after glitch", GPIO_IN_LEVEL, 32'h05);
        rdExpect("pending after glitch", GPIO_IN_PENDING, 32'h00);
        gpio_di = 8'h0D; idle(5);
        gpio_di = 8'h05; idle(2);
        rdExpect("pending after rise", GPIO_IN_PENDING, 32'h08);
        idle(8);
        rdExpect("pending after fall", GPIO_IN_PENDING, 32'h08);
        wrReg(GPIO_IN_PENDING, 32'hFF);

        // 4: W1C on the same edge the fall of bit 7 is detected: set wins
        wrReg(GPIO_IN_RISE_EN, 32'h00);
        wrReg(GPIO_IN_FALL_EN, 32'h80);
        gpio_di = 8'h85; idle(8);
        rdExpect("pending bit7 high", GPIO_IN_PENDING, 32'h00);
        gpio_di = 8'h05; idle(5);
        wrReg(GPIO_IN_PENDING, 32'h80);
        checkOutput("irq set wins", 32'(irq), 32'h1);
        rdExpect("pending set wins", GPIO_IN_PENDING, 32'h80);
        wrReg(GPIO_IN_PENDING, 32'h80);

        // 5: back-to-back accesses, all inputs low
        gpio_di = 8'h00; idle(8);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = GPIO_IN_RISE_EN; req_wdata = 32'h5A;
        applyStimulus();
        checkOutput("b2b write rsp", rsp_rdata, 32'h0);
        req_wr = 1'b0; req_addr = GPIO_IN_RISE_EN;
        applyStimulus();
        checkOutput("b2b read rise_en", rsp_rdata, 32'h5A);
        req_addr = GPIO_IN_LEVEL;
        applyStimulus();
        checkOutput("b2b read level", rsp_rdata, 32'h00);
        req_addr = 4'h0;
        applyStimulus();
        checkOutput("b2b read wrap", rsp_rdata, 32'h00);
        checkOutput("b2b last valid", 32'(rsp_valid), 32'h1);
        req_valid = 1'b0;
        applyStimulus();
        checkOutput("b2b idle valid", 32'(rsp_valid), 32'h0);

        // 6: reset pulse mid-debounce restarts the count; in-flight read dropped
        gpio_di = 8'h10; idle(4);
        reset_ = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = GPIO_IN_LEVEL;
        applyStimulus();
        req_valid = 1'b0; reset_ = 1'b1;
        checkOutput("reset drops rsp", 32'(rsp_valid), 32'h0);
        idle(5);
        rdExpect("level at 6th after reset", GPIO_IN_LEVEL, 32'h00);
        rdExpect("level at 7th after reset", GPIO_IN_LEVEL, 32'h10);

        // Random phase against the model
        holdLeft = 0;
        for (int c = 0; c < 400; c++) begin
            if (holdLeft == 0) begin
                gpio_di  = NR'($urandom);
                holdLeft = $urandom_range(1, 8);
            end
            holdLeft--;
            req_valid = $urandom_range(0, 1) == 1;
            req_wr    = $urandom_range(0, 2) == 0;
            req_addr  = 4'($urandom);
            req_wdata = $urandom;
            applyStimulus();
        end
        req_valid = 1'b0; req_wr = 1'b0;
        idle(10);
        rdExpect("final level", GPIO_IN_LEVEL, 32'(mLevel));
        rdExpect("final pending", GPIO_IN_PENDING, 32'(mPend));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
